// File: rtl/alu_result_writeback_pkg.sv
// Shared definitions for the ALU result writeback stage.
package alu_result_writeback_pkg;

  // Flag register bit positions, packed {P,S,C,Z}
  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_S = 2;
  localparam int unsigned FLG_P = 3;

  // Branch condition select codes
  localparam logic [2:0] COND_ALW = 3'd0;
  localparam logic [2:0] COND_Z   = 3'd1;
  localparam logic [2:0] COND_NZ  = 3'd2;
  localparam logic [2:0] COND_C   = 3'd3;
  localparam logic [2:0] COND_NC  = 3'd4;
  localparam logic [2:0] COND_PS  = 3'd5;
  localparam logic [2:0] COND_MI  = 3'd6;
  localparam logic [2:0] COND_PO  = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WB   = 1'b1
  } wb_state_t;

endpackage

// File: rtl/alu_result_writeback_flag_cond_eval.sv
// Combinational branch-condition evaluation from the stored flags.
module flag_cond_eval
  import alu_result_writeback_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] cond_sel,
  output logic       cond_true
);

  // Select one flag (or its complement) by condition code
  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      COND_ALW: cond_true = 1'b1;
      COND_Z:   cond_true = flags[FLG_Z];
      COND_NZ:  cond_true = ~flags[FLG_Z];
      COND_C:   cond_true = flags[FLG_C];
      COND_NC:  cond_true = ~flags[FLG_C];
      COND_PS:  cond_true = flags[FLG_S];
      COND_MI:  cond_true = ~flags[FLG_S];
      COND_PO:  cond_true = flags[FLG_P];
      default:  cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_result_writeback.sv
// Result/flag capture stage behind the ALU with a valid/ready writeback port.
module alu_result_writeback
  import alu_result_writeback_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEST_W   = 3,
  parameter logic [3:0]  FLAG_RST = 4'b0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [3:0]        alu_flags,
  input  logic              alu_valid,
  input  logic [3:0]        flag_we,
  input  logic              wb_en,
  input  logic [DEST_W-1:0] dest_sel,
  input  logic              flag_ld,
  input  logic [3:0]        flag_ld_data,
  input  logic [2:0]        cond_sel,
  input  logic              wb_ready,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [DEST_W-1:0] wb_dest,
  output logic [3:0]        flags_q,
  output logic              cin_out,
  output logic              cond_true,
  output logic              busy,
  output logic              drop_err
);

  wb_state_t state;
  logic      accept;
  logic      capture;

  assign busy     = (state == WB) & ~wb_ready;
  assign accept   = alu_valid & ~busy;
  assign capture  = accept & wb_en;
  assign wb_valid = (state == WB);
  assign cin_out  = flags_q[FLG_C];

  // Handshake FSM: any capture lands in WB, a completed handshake without a new capture returns to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (capture) begin
      state <= WB;
    end else if (state == WB && wb_ready) begin
      state <= IDLE;
    end
  end

  // Writeback data/destination registers, held while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_data <= '0;
      wb_dest <= '0;
    end else if (capture) begin
      wb_data <= alu_out;
      wb_dest <= dest_sel;
    end
  end

  // Flag register: direct load wins over a masked ALU update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= FLAG_RST;
    end else if (flag_ld) begin
      flags_q <= flag_ld_data;
    end else if (accept) begin
      flags_q <= (flag_we & alu_flags) | (~flag_we & flags_q);
    end
  end

  // Sticky record of a result offered while the stage was stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_err <= 1'b0;
    end else if (alu_valid && busy) begin
      drop_err <= 1'b1;
    end
  end

  flag_cond_eval u_cond (
    .flags     (flags_q),
    .cond_sel  (cond_sel),
    .cond_true (cond_true)
  );

endmodule

// File: tb/tb_alu_result_writeback.sv
// Directed self-checking bench for alu_result_writeback.
module tb_alu_result_writeback;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_out;
  logic [3:0] alu_flags;
  logic       alu_valid;
  logic [3:0] flag_we;
  logic       wb_en;
  logic [2:0] dest_sel;
  logic       flag_ld;
  logic [3:0] flag_ld_data;
  logic [2:0] cond_sel;
  logic       wb_ready;
  logic       wb_valid;
  logic [7:0] wb_data;
  logic [2:0] wb_dest;
  logic [3:0] flags_q;
  logic       cin_out;
  logic       cond_true;
  logic       busy;
  logic       drop_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_result_writeback #(
    .DATA_W   (8),
    .DEST_W   (3),
    .FLAG_RST (4'b0100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_out      (alu_out),
    .alu_flags    (alu_flags),
    .alu_valid    (alu_valid),
    .flag_we      (flag_we),
    .wb_en        (wb_en),
    .dest_sel     (dest_sel),
    .flag_ld      (flag_ld),
    .flag_ld_data (flag_ld_data),
    .cond_sel     (cond_sel),
    .wb_ready     (wb_ready),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_dest      (wb_dest),
    .flags_q      (flags_q),
    .cin_out      (cin_out),
    .cond_true    (cond_true),
    .busy         (busy),
    .drop_err     (drop_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; alu_out = '0; alu_flags = '0; alu_valid = 1'b0; flag_we = '0;
    wb_en = 1'b0; dest_sel = '0; flag_ld = 1'b0; flag_ld_data = '0;
    cond_sel = '0; wb_ready = 1'b0;
    #3;
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_flags", 32'(flags_q), 32'h4);
    chk("rst_cin", 32'(cin_out), 32'h0);
    chk("rst_drop", 32'(drop_err), 32'h0);
    chk("rst_data", 32'(wb_data), 32'h0);
    chk("rst_dest", 32'(wb_dest), 32'h0);
    step(); step();
    rst = 1'b0;
    step();

    // single writeback
    alu_out = 8'h3C; alu_flags = 4'b0100; flag_we = 4'hF; wb_en = 1'b1;
    dest_sel = 3'd5; wb_ready = 1'b1; alu_valid = 1'b1;
    step();
    alu_valid = 1'b0;
    chk("wb1_valid", 32'(wb_valid), 32'h1);
    chk("wb1_data", 32'(wb_data), 32'h3C);
    chk("wb1_dest", 32'(wb_dest), 32'h5);
    chk("wb1_flags", 32'(flags_q), 32'h4);
    chk("wb1_busy", 32'(busy), 32'h0);
    step();
    chk("wb1_done", 32'(wb_valid), 32'h0);

    // stall then drop
    wb_ready = 1'b0; alu_valid = 1'b1;
    step();
    alu_valid = 1'b0;
    chk("stall_valid", 32'(wb_valid), 32'h1);
    chk("stall_busy", 32'(busy), 32'h1);
    alu_out = 8'hFF; alu_flags = 4'b1011; flag_we = 4'hF; alu_valid = 1'b1;
    step();
    alu_valid = 1'b0;
    chk("drop_err", 32'(drop_err), 32'h1);
    chk("drop_data", 32'(wb_data), 32'h3C);
    chk("drop_flags", 32'(flags_q), 32'h4);
    chk("drop_valid", 32'(wb_valid), 32'h1);

    // back-to-back
    wb_ready = 1'b1; alu_flags = 4'b0100; alu_valid = 1'b1;
    alu_out = 8'h01; dest_sel = 3'd1;
    step();
    chk("b2b1_data", 32'(wb_data), 32'h01);
    chk("b2b1_valid", 32'(wb_valid), 32'h1);
    alu_out = 8'h02; dest_sel = 3'd2;
    step();
    chk("b2b2_data", 32'(wb_data), 32'h02);
    chk("b2b2_valid", 32'(wb_valid), 32'h1);
    alu_out = 8'h03; dest_sel = 3'd3;
    step();
    alu_valid = 1'b0;
    chk("b2b3_data", 32'(wb_data), 32'h03);
    chk("b2b3_dest", 32'(wb_dest), 32'h3);
    chk("b2b3_valid", 32'(wb_valid), 32'h1);
    step();
    chk("b2b_done", 32'(wb_valid), 32'h0);
    chk("drop_sticky", 32'(drop_err), 32'h1);

    // masked flags-only update
    flag_ld = 1'b1; flag_ld_data = 4'b0000;
    step();
    flag_ld = 1'b0;
    chk("ld_zero", 32'(flags_q), 32'h0);
    cond_sel = 3'd0; #1;
    chk("cond_alw", 32'(cond_true), 32'h1);
    alu_valid = 1'b1; wb_en = 1'b0; alu_flags = 4'b1011; flag_we = 4'b0011;
    step();
    alu_valid = 1'b0;
    chk("mask_flags", 32'(flags_q), 32'h3);
    chk("mask_cin", 32'(cin_out), 32'h1);
    chk("mask_nowb", 32'(wb_valid), 32'h0);
    cond_sel = 3'd1; #1; chk("cond_z", 32'(cond_true), 32'h1);
    cond_sel = 3'd2; #1; chk("cond_nz", 32'(cond_true), 32'h0);
    cond_sel = 3'd3; #1; chk("cond_c", 32'(cond_true), 32'h1);
    cond_sel = 3'd4; #1; chk("cond_nc", 32'(cond_true), 32'h0);
    cond_sel = 3'd5; #1; chk("cond_ps", 32'(cond_true), 32'h0);
    cond_sel = 3'd6; #1; chk("cond_mi", 32'(cond_true), 32'h1);
    cond_sel = 3'd7; #1; chk("cond_po", 32'(cond_true), 32'h0);

    // load priority with simultaneous capture
    @(posedge clk); #1;
    flag_ld = 1'b1; flag_ld_data = 4'b1000; alu_valid = 1'b1; alu_flags = 4'b0001;
    flag_we = 4'hF; wb_en = 1'b1; alu_out = 8'h5A; dest_sel = 3'd7; wb_ready = 1'b1;
    step();
    flag_ld = 1'b0; alu_valid = 1'b0;
    chk("ldp_flags", 32'(flags_q), 32'h8);
    chk("ldp_cond_po", 32'(cond_true), 32'h1);
    chk("ldp_valid", 32'(wb_valid), 32'h1);
    chk("ldp_data", 32'(wb_data), 32'h5A);
    chk("ldp_dest", 32'(wb_dest), 32'h7);
    step();

    // asynchronous reset mid-handshake
    wb_ready = 1'b0; alu_valid = 1'b1; alu_out = 8'h77; dest_sel = 3'd2;
    step();
    alu_valid = 1'b0;
    chk("mid_valid", 32'(wb_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(wb_valid), 32'h0);
    chk("arst_flags", 32'(flags_q), 32'h4);
    chk("arst_cin", 32'(cin_out), 32'h0);
    chk("arst_drop", 32'(drop_err), 32'h0);
    chk("arst_data", 32'(wb_data), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_valid", 32'(wb_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
